skywater_nand_dline_ctrl: RTL and testbench
===========================================

Name: skywater_nand_dline_ctrl

Overview:
Multi-channel, supply-aware controller and behavioural model for NAND-stage delay lines in the AIB AMS clock path.
- Each channel holds a delay code and drives a thermometer enable bus to a NUM_STAGES-deep NAND chain.
- Code changes are applied through a four-phase req/ack handshake with a settle interval, so the line is never retuned mid-update.
- Each channel also models the chain: din delayed by a code-dependent number of NAND gate delays.

Parameters:
NUM_CH, 2, number of independent delay-line channels
NUM_STAGES, 16, NAND stages per line; valid codes 0..NUM_STAGES
CODE_W, 5, code width; must satisfy 2**CODE_W > NUM_STAGES
SETTLE_CYC, 3, clk cycles the new code is held before ack (>=1)
RST_CODE, 8, code loaded on reset (<= NUM_STAGES)
DELAY, 20, per-NAND-stage delay in ps for the din->dout model

Ports:
clk  input  1  control clock
rstb  input  1  asynchronous active-low reset
req  input  NUM_CH  per-channel update request, four-phase
op  input  2*NUM_CH  per-channel opcode: 00 hold, 01 inc, 10 dec, 11 load
load_code  input  CODE_W*NUM_CH  per-channel absolute code for op=11
ack  output  NUM_CH  per-channel update acknowledge
code  output  CODE_W*NUM_CH  current code per channel
en  output  NUM_STAGES*NUM_CH  thermometer stage enables per channel
sat  output  NUM_CH  update clipped/saturated flag
din  input  NUM_CH  per-channel signal into the delay line
dout  output  NUM_CH  delayed signal per channel

Behaviour:
- The block has one clock, clk, and an asynchronous active-low reset, rstb.
- Reset, rstb=0, acting immediately on every channel:
  - code=RST_CODE, en=thermometer(RST_CODE), ack=0, sat=0, FSM=IDLE, settle counter=0.
  - Reset mid-update aborts the update; the pending op is discarded.
- Thermometer mapping: en[ch][i]=1 iff i<code[ch]. Code 0 gives all zeros; NUM_STAGES gives all ones.
- Per-channel FSM states are IDLE, SETTLE, ACK. All channels are independent and may be in different states.
- IDLE:
  - On a clk edge with req=1, latch op/load_code, compute the next code, write code and en on that edge, load the counter with SETTLE_CYC-1, go to SETTLE.
  - sat is updated on the same edge.
  - req=0: remain in IDLE.
- Next-code rules:
  - inc: code+1 if code<NUM_STAGES, else unchanged and sat=1.
  - dec: code-1 if code>0, else unchanged and sat=1.
  - load: min(load_code, NUM_STAGES); sat=1 if clipped.
  - hold: unchanged, sat=0.
  - Otherwise sat=0. sat holds its value until the next accepted request.
- SETTLE: decrement the counter each cycle. At 0, go to ACK and assert ack on that edge. Latency from the req sample edge to ack=1 is SETTLE_CYC cycles.
- ACK: ack stays 1 while req=1. On req=0, deassert ack and go to IDLE.
  - A new request needs a req low phase, so at most one update per handshake.
  - Changes to op or load_code outside the IDLE sample edge are ignored.
- dout[ch] follows din[ch] with a transport delay of (code[ch]+1)*DELAY ps: the always-on entry NAND plus the enabled stages. Inversion parity is even. With code=0 the delay is DELAY.
- No arithmetic wraps: all inc/dec saturate.

Optional Feature:
SKYWATER_DLINE_SUPPLY_CHK_EN
- Defined:
  - Adds inout ports VDD and VSS.
  - Any dout[ch] is 1'bx while VSS=1, and 0 while VDD=0.
  - The control logic (code, en, ack, sat) is unaffected.
  - A wrapper without supplies ties VDD=1 and VSS=0, matching the existing skywater gate models.
- Undefined: no supply ports; dout is always the delayed din.

Decomposition:
- Package skywater_dline_pkg holds:
  - the opcode typedef and constants OP_HOLD, OP_INC, OP_DEC, OP_LOAD;
  - the FSM state typedef (IDLE, SETTLE, ACK);
  - a thermometer-encode function.
- Sub-module skywater_dline_ch implements one channel: FSM, saturating code register, en, and the delay model. The top instantiates NUM_CH copies in a generate loop.

Test Plan:
- Reset release → code=8, en=16'h00FF, ack=0, sat=0 on all channels. Assert rstb=0 mid-SETTLE → ack=0 and code=8 immediately.
- ch0 op=01 req pulse → code=9 on the sample edge, ack=1 exactly 3 cycles later, ack=0 one cycle after req falls.
- ch1 load 20 → code=16, en=16'hFFFF, sat=1. Then dec → code=15, sat=0.
- ch0 at code 0, dec → code stays 0, sat=1. Simultaneous ch1 inc completes independently and its ack timing is unaffected.
- din step at code=4 → dout edge 100 ps later; at code=0 → 20 ps later.
- With SKYWATER_DLINE_SUPPLY_CHK_EN, VSS=1 → dout=x; VDD=0 → dout=0; code path unchanged.

Source files
------------

// File: rtl/skywater_dline_pkg.sv
// -----------------------------------------------------------------------------
// skywater_dline_pkg
// Shared types and helpers for the NAND-stage delay-line controller.
//   op_e    : per-channel update opcode (hold / inc / dec / load)
//   state_e : per-channel handshake FSM state (IDLE, SETTLE, ACK)
//   thermo  : code -> thermometer stage-enable encoder
// -----------------------------------------------------------------------------
`timescale 1ps/1ps

package skywater_dline_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACK    = 2'd2
  } state_e;

  // Widest chain the encoder supports; callers truncate to their stage count.
  localparam int unsigned THERMO_MAX = 64;

  // Bit i of the result is set iff i < n.
  function automatic logic [THERMO_MAX-1:0] thermo(input int unsigned n);
    logic [THERMO_MAX-1:0] one;
    one = {{(THERMO_MAX-1){1'b0}}, 1'b1};
    if (n >= THERMO_MAX) return '1;
    return (one << n) - one;
  endfunction

endpackage

// File: rtl/skywater_dline_ch.sv
// -----------------------------------------------------------------------------
// skywater_dline_ch
// One delay-line channel: four-phase update handshake FSM, saturating code
// register, thermometer stage enables and a behavioural din->dout chain model.
//
// Ports:
//   clk, rstb       control clock, asynchronous active-low reset
//   req             four-phase update request
//   op, load_code   opcode and absolute code, sampled only on the IDLE req edge
//   ack             update acknowledge (SETTLE_CYC cycles after the sample edge)
//   code, en        current code and its thermometer stage enables
//   sat             last accepted update was clipped/saturated
//   din, dout       signal into / out of the modelled NAND chain
//   VDD, VSS        supply pins, present only with SKYWATER_DLINE_SUPPLY_CHK_EN
//
// Optional feature macro: SKYWATER_DLINE_SUPPLY_CHK_EN
// -----------------------------------------------------------------------------
`timescale 1ps/1ps

module skywater_dline_ch
  import skywater_dline_pkg::*;
#(
  parameter int NUM_STAGES = 16,
  parameter int CODE_W     = 5,
  parameter int SETTLE_CYC = 3,
  parameter int RST_CODE   = 8,
  parameter int DELAY      = 20
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  req,
  input  logic [1:0]            op,
  input  logic [CODE_W-1:0]     load_code,
  output logic                  ack,
  output logic [CODE_W-1:0]     code,
  output logic [NUM_STAGES-1:0] en,
  output logic                  sat,
  input  logic                  din,
  output logic                  dout
`ifdef SKYWATER_DLINE_SUPPLY_CHK_EN
  ,
  inout  wire                   VDD,
  inout  wire                   VSS
`endif
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CODE_W-1:0] MAX_CODE  = CODE_W'(NUM_STAGES);
  localparam logic [CODE_W-1:0] RST_VAL   = CODE_W'(RST_CODE);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE_CYC - 1);

  state_e             r_state, w_state_nxt;
  logic [CODE_W-1:0]  r_code,  w_code_nxt;
  logic               r_sat,   w_sat_nxt;
  logic               r_ack,   w_ack_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic               r_dline;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= IDLE;
      r_code  <= RST_VAL;
      r_sat   <= 1'b0;
      r_ack   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational block, in any order.
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_sat   <= w_sat_nxt;
      r_ack   <= w_ack_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_sat_nxt   = r_sat;
    w_ack_nxt   = r_ack;
    w_cnt_nxt   = r_cnt;

    unique case (r_state)
      IDLE: begin
        if (req) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = CNT_LOAD;
          w_sat_nxt   = 1'b0;
          case (op_e'(op))
            OP_HOLD: ;
            OP_INC: begin
              if (r_code < MAX_CODE) w_code_nxt = r_code + 1'b1;
              else                   w_sat_nxt  = 1'b1;
            end
            OP_DEC: begin
              if (r_code != '0) w_code_nxt = r_code - 1'b1;
              else              w_sat_nxt  = 1'b1;
            end
            OP_LOAD: begin
              if (load_code > MAX_CODE) begin
                w_code_nxt = MAX_CODE;
                w_sat_nxt  = 1'b1;
              end else begin
                w_code_nxt = load_code;
              end
            end
          endcase
        end
      end
      SETTLE: begin
        // Counter was loaded with SETTLE_CYC-1, so ack rises SETTLE_CYC
        // edges after the request sample edge.
        if (r_cnt == '0) begin
          w_state_nxt = ACK;
          w_ack_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ACK: begin
        // Leaving only on req low forces a low phase between updates.
        if (!req) begin
          w_state_nxt = IDLE;
          w_ack_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ack_nxt   = 1'b0;
      end
    endcase
  end

  assign code = r_code;
  assign sat  = r_sat;
  assign ack  = r_ack;
  assign en   = NUM_STAGES'(thermo(32'(r_code)));

  // Behavioural model of the analog chain (simulation only): transport delay
  // of the always-on entry NAND plus one gate delay per enabled stage.
  always @(din) begin
    r_dline <= #((int'(r_code) + 1) * DELAY) din;
  end

`ifdef SKYWATER_DLINE_SUPPLY_CHK_EN
  assign dout = VSS ? 1'bx : (!VDD ? 1'b0 : r_dline);
`else
  assign dout = r_dline;
`endif

endmodule

// File: rtl/skywater_nand_dline_ctrl.sv
// -----------------------------------------------------------------------------
// skywater_nand_dline_ctrl
// Multi-channel, supply-aware controller and behavioural model for NAND-stage
// delay lines. Channel ch owns slice ch of every flattened bus.
//
// Ports:
//   clk, rstb   control clock, asynchronous active-low reset
//   req[ch]     per-channel four-phase update request
//   op          2 bits/channel: 00 hold, 01 inc, 10 dec, 11 load
//   load_code   CODE_W bits/channel absolute code for load
//   ack[ch]     per-channel update acknowledge
//   code        CODE_W bits/channel current code
//   en          NUM_STAGES bits/channel thermometer stage enables
//   sat[ch]     per-channel clipped/saturated flag
//   din, dout   per-channel delay-line input and delayed output
//   VDD, VSS    supply pins, present only with SKYWATER_DLINE_SUPPLY_CHK_EN
//
// Optional feature macro: SKYWATER_DLINE_SUPPLY_CHK_EN
// -----------------------------------------------------------------------------
`timescale 1ps/1ps

module skywater_nand_dline_ctrl #(
  parameter int NUM_CH     = 2,
  parameter int NUM_STAGES = 16,
  parameter int CODE_W     = 5,
  parameter int SETTLE_CYC = 3,
  parameter int RST_CODE   = 8,
  parameter int DELAY      = 20
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic [NUM_CH-1:0]            req,
  input  logic [2*NUM_CH-1:0]          op,
  input  logic [CODE_W*NUM_CH-1:0]     load_code,
  output logic [NUM_CH-1:0]            ack,
  output logic [CODE_W*NUM_CH-1:0]     code,
  output logic [NUM_STAGES*NUM_CH-1:0] en,
  output logic [NUM_CH-1:0]            sat,
  input  logic [NUM_CH-1:0]            din,
  output logic [NUM_CH-1:0]            dout
`ifdef SKYWATER_DLINE_SUPPLY_CHK_EN
  ,
  inout  wire                          VDD,
  inout  wire                          VSS
`endif
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    skywater_dline_ch #(
      .NUM_STAGES (NUM_STAGES),
      .CODE_W     (CODE_W),
      .SETTLE_CYC (SETTLE_CYC),
      .RST_CODE   (RST_CODE),
      .DELAY      (DELAY)
    ) u_ch (
      .clk       (clk),
      .rstb      (rstb),
      .req       (req[g]),
      .op        (op[2*g +: 2]),
      .load_code (load_code[CODE_W*g +: CODE_W]),
      .ack       (ack[g]),
      .code      (code[CODE_W*g +: CODE_W]),
      .en        (en[NUM_STAGES*g +: NUM_STAGES]),
      .sat       (sat[g]),
      .din       (din[g]),
      .dout      (dout[g])
`ifdef SKYWATER_DLINE_SUPPLY_CHK_EN
      ,
      .VDD       (VDD),
      .VSS       (VSS)
`endif
    );
  end

endmodule

// File: tb/tb_skywater_nand_dline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_skywater_nand_dline_ctrl
// Directed, self-checking bench for skywater_nand_dline_ctrl (default params:
// 2 channels, 16 stages, 5-bit code, settle 3, reset code 8, 20 ps/stage).
// Inputs change on the falling edge, outputs are sampled 1 ps after rising.
// -----------------------------------------------------------------------------
`timescale 1ps/1ps

module tb_skywater_nand_dline_ctrl;

  logic        clk = 1'b0;
  logic        rstb;
  logic [1:0]  req;
  logic [3:0]  op;
  logic [9:0]  load_code;
  logic [1:0]  din;
  wire  [1:0]  ack;
  wire  [9:0]  code;
  wire  [31:0] en;
  wire  [1:0]  sat;
  wire  [1:0]  dout;

  int tests_run    = 0;
  int tests_failed = 0;
  int n;

`ifdef SKYWATER_DLINE_SUPPLY_CHK_EN
  logic vdd_drv = 1'b1;
  logic vss_drv = 1'b0;
  wire  VDD = vdd_drv;
  wire  VSS = vss_drv;
`endif

  skywater_nand_dline_ctrl dut (
    .clk       (clk),
    .rstb      (rstb),
    .req       (req),
    .op        (op),
    .load_code (load_code),
    .ack       (ack),
    .code      (code),
    .en        (en),
    .sat       (sat),
    .din       (din),
    .dout      (dout)
`ifdef SKYWATER_DLINE_SUPPLY_CHK_EN
    ,
    .VDD       (VDD),
    .VSS       (VSS)
`endif
  );

  always #500 clk = ~clk;

  function automatic logic [4:0] code_of(input int ch);
    return code[5*ch +: 5];
  endfunction

  function automatic logic [15:0] en_of(input int ch);
    return en[16*ch +: 16];
  endfunction

  task automatic start_req(input int ch, input logic [1:0] o, input logic [4:0] lc);
    @(negedge clk);
    op[2*ch +: 2]        = o;
    load_code[5*ch +: 5] = lc;
    req[ch]              = 1'b1;
  endtask

  task automatic drop_req(input int ch);
    @(negedge clk);
    req[ch] = 1'b0;
  endtask

  // Rising edges until ack[ch]==want (1-based), or -1 after 20 edges.
  task automatic wait_ack(input int ch, input logic want, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack[ch] === want) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic finish_hs(input int ch);
    int c;
    wait_ack(ch, 1'b1, c);
    drop_req(ch);
    wait_ack(ch, 1'b0, c);
  endtask

  task automatic test_reset;
    rstb = 1'b0; req = '0; op = '0; load_code = '0; din = '0;
    repeat (3) @(negedge clk);
    tests_run++; if (ack !== 2'b00) begin tests_failed++; $display("FAIL rst_ack_in_reset: got %b want 00", ack); end
    rstb = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (code_of(0) !== 5'd8) begin tests_failed++; $display("FAIL rst_code0: got %0d want 8", code_of(0)); end
    tests_run++; if (code_of(1) !== 5'd8) begin tests_failed++; $display("FAIL rst_code1: got %0d want 8", code_of(1)); end
    tests_run++; if (en_of(0) !== 16'h00FF) begin tests_failed++; $display("FAIL rst_en0: got %h want 00ff", en_of(0)); end
    tests_run++; if (en_of(1) !== 16'h00FF) begin tests_failed++; $display("FAIL rst_en1: got %h want 00ff", en_of(1)); end
    tests_run++; if (ack !== 2'b00) begin tests_failed++; $display("FAIL rst_ack: got %b want 00", ack); end
    tests_run++; if (sat !== 2'b00) begin tests_failed++; $display("FAIL rst_sat: got %b want 00", sat); end
  endtask

  task automatic test_inc_handshake;
    start_req(0, 2'b01, 5'd0);
    @(posedge clk); #1;
    tests_run++; if (code_of(0) !== 5'd9) begin tests_failed++; $display("FAIL inc_code: got %0d want 9", code_of(0)); end
    tests_run++; if (en_of(0) !== 16'h01FF) begin tests_failed++; $display("FAIL inc_en: got %h want 01ff", en_of(0)); end
    tests_run++; if (sat[0] !== 1'b0) begin tests_failed++; $display("FAIL inc_sat: got %b want 0", sat[0]); end
    tests_run++; if (ack[0] !== 1'b0) begin tests_failed++; $display("FAIL inc_ack_early: got %b want 0", ack[0]); end
    op[1:0] = 2'b10;  // must be ignored outside the IDLE sample edge
    wait_ack(0, 1'b1, n);
    tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL inc_ack_latency: got %0d want 3", n); end
    repeat (2) @(posedge clk); #1;
    tests_run++; if (ack[0] !== 1'b1) begin tests_failed++; $display("FAIL inc_ack_hold: got %b want 1", ack[0]); end
    tests_run++; if (code_of(0) !== 5'd9) begin tests_failed++; $display("FAIL inc_op_ignored: got %0d want 9", code_of(0)); end
    drop_req(0);
    @(posedge clk); #1;
    tests_run++; if (ack[0] !== 1'b0) begin tests_failed++; $display("FAIL inc_ack_release: got %b want 0", ack[0]); end
  endtask

  task automatic test_load_sat;
    start_req(1, 2'b11, 5'd20);
    @(posedge clk); #1;
    tests_run++; if (code_of(1) !== 5'd16) begin tests_failed++; $display("FAIL load_clip_code: got %0d want 16", code_of(1)); end
    tests_run++; if (en_of(1) !== 16'hFFFF) begin tests_failed++; $display("FAIL load_clip_en: got %h want ffff", en_of(1)); end
    tests_run++; if (sat[1] !== 1'b1) begin tests_failed++; $display("FAIL load_clip_sat: got %b want 1", sat[1]); end
    wait_ack(1, 1'b1, n);
    tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL load_ack_latency: got %0d want 3", n); end
    drop_req(1);
    wait_ack(1, 1'b0, n);
    tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL load_ack_release: got %0d want 1", n); end
    tests_run++; if (sat[1] !== 1'b1) begin tests_failed++; $display("FAIL load_sat_held: got %b want 1", sat[1]); end
    start_req(1, 2'b10, 5'd0);
    @(posedge clk); #1;
    tests_run++; if (code_of(1) !== 5'd15) begin tests_failed++; $display("FAIL dec_code: got %0d want 15", code_of(1)); end
    tests_run++; if (en_of(1) !== 16'h7FFF) begin tests_failed++; $display("FAIL dec_en: got %h want 7fff", en_of(1)); end
    tests_run++; if (sat[1] !== 1'b0) begin tests_failed++; $display("FAIL dec_sat: got %b want 0", sat[1]); end
    finish_hs(1);
  endtask

  task automatic test_floor_parallel;
    start_req(0, 2'b11, 5'd0);
    @(posedge clk); #1;
    tests_run++; if (code_of(0) !== 5'd0) begin tests_failed++; $display("FAIL load0_code: got %0d want 0", code_of(0)); end
    tests_run++; if (en_of(0) !== 16'h0000) begin tests_failed++; $display("FAIL load0_en: got %h want 0000", en_of(0)); end
    finish_hs(0);
    @(negedge clk);
    op  = 4'b0110;  // ch1 inc, ch0 dec
    req = 2'b11;
    @(posedge clk); #1;
    tests_run++; if (code_of(0) !== 5'd0) begin tests_failed++; $display("FAIL floor_code: got %0d want 0", code_of(0)); end
    tests_run++; if (sat[0] !== 1'b1) begin tests_failed++; $display("FAIL floor_sat: got %b want 1", sat[0]); end
    tests_run++; if (code_of(1) !== 5'd16) begin tests_failed++; $display("FAIL par_inc_code: got %0d want 16", code_of(1)); end
    tests_run++; if (sat[1] !== 1'b0) begin tests_failed++; $display("FAIL par_inc_sat: got %b want 0", sat[1]); end
    wait_ack(1, 1'b1, n);
    tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL par_ack1_latency: got %0d want 3", n); end
    tests_run++; if (ack[0] !== 1'b1) begin tests_failed++; $display("FAIL par_ack0: got %b want 1", ack[0]); end
    drop_req(1);
    @(posedge clk); #1;
    tests_run++; if (ack !== 2'b01) begin tests_failed++; $display("FAIL par_release_ch1_only: got %b want 01", ack); end
    drop_req(0);
    wait_ack(0, 1'b0, n);
    tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL par_release_ch0: got %0d want 1", n); end
  endtask

  task automatic test_delay;
    start_req(0, 2'b11, 5'd4);
    finish_hs(0);
    tests_run++; if (code_of(0) !== 5'd4) begin tests_failed++; $display("FAIL dly_code4: got %0d want 4", code_of(0)); end
    // Prime the model outputs to a known low level (ch1 is at code 16).
    din = 2'b11; #600;
    din = 2'b00; #600;
    din = 2'b11;
    #99;
    tests_run++; if (dout[0] !== 1'b0) begin tests_failed++; $display("FAIL dly4_before: got %b want 0", dout[0]); end
    #2;
    tests_run++; if (dout[0] !== 1'b1) begin tests_failed++; $display("FAIL dly4_after: got %b want 1", dout[0]); end
    #238;  // t = 339 ps after the step
    tests_run++; if (dout[1] !== 1'b0) begin tests_failed++; $display("FAIL dly16_before: got %b want 0", dout[1]); end
    #2;
    tests_run++; if (dout[1] !== 1'b1) begin tests_failed++; $display("FAIL dly16_after: got %b want 1", dout[1]); end
    start_req(0, 2'b11, 5'd0);
    finish_hs(0);
    din[0] = 1'b0;
    #19;
    tests_run++; if (dout[0] !== 1'b1) begin tests_failed++; $display("FAIL dly0_before: got %b want 1", dout[0]); end
    #2;
    tests_run++; if (dout[0] !== 1'b0) begin tests_failed++; $display("FAIL dly0_after: got %b want 0", dout[0]); end
  endtask

  task automatic test_reset_mid_settle;
    start_req(0, 2'b01, 5'd0);
    @(posedge clk); #1;
    tests_run++; if (code_of(0) !== 5'd1) begin tests_failed++; $display("FAIL mid_pre_code: got %0d want 1", code_of(0)); end
    req = 2'b00;
    #100;
    rstb = 1'b0;
    #1;
    tests_run++; if (ack[0] !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_ack: got %b want 0", ack[0]); end
    tests_run++; if (code_of(0) !== 5'd8) begin tests_failed++; $display("FAIL mid_rst_code0: got %0d want 8", code_of(0)); end
    tests_run++; if (code_of(1) !== 5'd8) begin tests_failed++; $display("FAIL mid_rst_code1: got %0d want 8", code_of(1)); end
    tests_run++; if (en_of(0) !== 16'h00FF) begin tests_failed++; $display("FAIL mid_rst_en0: got %h want 00ff", en_of(0)); end
    tests_run++; if (sat !== 2'b00) begin tests_failed++; $display("FAIL mid_rst_sat: got %b want 00", sat); end
    @(negedge clk);
    rstb = 1'b1;
    repeat (5) @(posedge clk); #1;
    tests_run++; if (ack[0] !== 1'b0) begin tests_failed++; $display("FAIL mid_discard_ack: got %b want 0", ack[0]); end
    tests_run++; if (code_of(0) !== 5'd8) begin tests_failed++; $display("FAIL mid_discard_code: got %0d want 8", code_of(0)); end
  endtask

`ifdef SKYWATER_DLINE_SUPPLY_CHK_EN
  task automatic test_supply;
    vss_drv = 1'b1; #1;
    tests_run++; if (dout[0] !== 1'bx) begin tests_failed++; $display("FAIL sup_vss_x: got %b want x", dout[0]); end
    vss_drv = 1'b0; vdd_drv = 1'b0; #1;
    tests_run++; if (dout[0] !== 1'b0) begin tests_failed++; $display("FAIL sup_vdd_0: got %b want 0", dout[0]); end
    tests_run++; if (code_of(0) !== 5'd8) begin tests_failed++; $display("FAIL sup_code: got %0d want 8", code_of(0)); end
    vdd_drv = 1'b1; #1;
  endtask
`endif

  initial begin
    test_reset();
    test_inc_handshake();
    test_load_sat();
    test_floor_parallel();
    test_delay();
    test_reset_mid_settle();
`ifdef SKYWATER_DLINE_SUPPLY_CHK_EN
    test_supply();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
